// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: IR opcode and memory handshake in, mux/enable strobes out.
// master = control unit side, slave = datapath side.
interface multicycle_control_unit_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 2
);
    logic [INSTR_W-1:0] instruction;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemToReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         PCSource;
    logic [3:0]         state;
    logic               illegal;
    logic               mem_timeout;

    modport master (
        input  instruction, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state,
               illegal, mem_timeout
    );

    modport slave (
        output instruction, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state,
               illegal, mem_timeout
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM (FETCH/DECODE/EXECUTE/MEM/WB) with memory wait timeout.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module multicycle_control_unit #(
    parameter int INSTR_W     = 32,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_unit_if.master  bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                cycle_cnt,
    output logic [31:0]                instr_cnt
`endif
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ      = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam int         CNT_W   = $clog2(MEM_TIMEOUT + 2);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wait;
    logic [5:0]         w_op;
    logic               w_wait_st;
    logic               w_timeout;
    logic               w_unused;

    logic               w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
    logic               w_MemToReg, w_RegDst, w_RegWrite, w_ALUSrcA, w_illegal;
    logic [1:0]         w_ALUSrcB, w_PCSource;
    logic [ALUOP_W-1:0] w_ALUOp;

    assign w_op      = bus.instruction[INSTR_W-1 -: 6];
    assign w_unused  = ^bus.instruction[INSTR_W-7:0];
    assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // r_wait holds the number of completed wait cycles, so the Nth wait cycle sees N-1.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_wait_st && !bus.mem_ready &&
                       (r_wait == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Leaving a state (or a timeout re-entering FETCH) restarts the count; it saturates otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if ((w_next != r_state) || w_timeout) begin
            r_wait <= '0;
        end else if (w_wait_st && !bus.mem_ready && (r_wait != '1)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_PCWrite     = 1'b0;
        w_PCWriteCond = 1'b0;
        w_IorD        = 1'b0;
        w_MemRead     = 1'b0;
        w_MemWrite    = 1'b0;
        w_IRWrite     = 1'b0;
        w_MemToReg    = 1'b0;
        w_RegDst      = 1'b0;
        w_RegWrite    = 1'b0;
        w_ALUSrcA     = 1'b0;
        w_ALUSrcB     = 2'b00;
        w_ALUOp       = '0;
        w_PCSource    = 2'b00;
        w_illegal     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_MemRead = 1'b1;
                w_ALUSrcB = 2'b01;
                if (bus.mem_ready) begin
                    w_IRWrite = 1'b1;
                    w_PCWrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ALUSrcB = 2'b11;
                case (w_op)
                    OP_R:         w_next = S_RTYPE_EX;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EX;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ALUSrcA = 1'b1;
                w_ALUSrcB = 2'b10;
                w_next    = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_MemRead = 1'b1;
                w_IorD    = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_RegWrite = 1'b1;
                w_MemToReg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_MemWrite = 1'b1;
                w_IorD     = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
            end
            S_RTYPE_EX: begin
                w_ALUSrcA = 1'b1;
                w_ALUOp   = ALUOP_W'(2'b10);
                w_next    = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                w_RegWrite = 1'b1;
                w_RegDst   = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_ALUSrcA     = 1'b1;
                w_ALUOp       = ALUOP_W'(2'b01);
                w_PCWriteCond = 1'b1;
                w_PCSource    = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                w_PCWrite  = 1'b1;
                w_PCSource = 2'b10;
                w_next     = S_FETCH;
            end
            S_ADDI_EX: begin
                w_ALUSrcA = 1'b1;
                w_ALUSrcB = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_RegWrite = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_MemRead  = 1'b0;
            w_MemWrite = 1'b0;
            w_IRWrite  = 1'b0;
            w_PCWrite  = 1'b0;
            w_next     = S_FETCH;
        end
    end

    assign bus.PCWrite     = w_PCWrite;
    assign bus.PCWriteCond = w_PCWriteCond;
    assign bus.IorD        = w_IorD;
    assign bus.MemRead     = w_MemRead;
    assign bus.MemWrite    = w_MemWrite;
    assign bus.IRWrite     = w_IRWrite;
    assign bus.MemToReg    = w_MemToReg;
    assign bus.RegDst      = w_RegDst;
    assign bus.RegWrite    = w_RegWrite;
    assign bus.ALUSrcA     = w_ALUSrcA;
    assign bus.ALUSrcB     = w_ALUSrcB;
    assign bus.ALUOp       = w_ALUOp;
    assign bus.PCSource    = w_PCSource;
    assign bus.state       = r_state;
    assign bus.illegal     = w_illegal;
    assign bus.mem_timeout = w_timeout;

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (r_state != S_IDLE) cycle_cnt <= cycle_cnt + 32'd1;
            if ((r_state == S_DECODE) && !w_illegal) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver walks each instruction through its expected state sequence
// and queues per-cycle expectations; a negedge monitor pops and compares every cycle.
module tb_multicycle_control_unit;
    localparam int TO = 4;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemToReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic       illegal;
        logic       mem_timeout;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cur_instr;
    exp_t        exp_q[$];
    ctrl_t       nom[13];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          drv_done = 1'b0;

    multicycle_control_unit_if #(.INSTR_W(32), .ALUOP_W(2)) bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    multicycle_control_unit #(.INSTR_W(32), .ALUOP_W(2), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
    multicycle_control_unit #(.INSTR_W(32), .ALUOP_W(2), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic mr, input int st, input ctrl_t e);
        exp_t x;
        @(posedge clk); #1;
        bus.mem_ready   = mr;
        bus.instruction = cur_instr;
        x.st = 4'(st);
        x.c  = e;
        exp_q.push_back(x);
    endtask

    task automatic rst_cycle(input logic v);
        exp_t x;
        @(posedge clk); #1;
        rst_n         = v;
        bus.mem_ready = rnd();
        x = '0;
        exp_q.push_back(x);
    endtask

    // A memory-wait state: `waits` cycles without ready, then the completing cycle,
    // unless the TO-th waiting cycle fires the timeout first.
    task automatic mem_phase(input int st, input int waits, output bit timed_out);
        ctrl_t e;
        timed_out = 1'b0;
        for (int k = 1; k <= waits; k++) begin
            e = nom[st];
            if (k == TO) begin
                e.mem_timeout = 1'b1;
                e.MemRead     = 1'b0;
                e.MemWrite    = 1'b0;
                step(1'b0, st, e);
                timed_out = 1'b1;
                return;
            end
            step(1'b0, st, e);
        end
        e = nom[st];
        if (st == 1) begin
            e.IRWrite = 1'b1;
            e.PCWrite = 1'b1;
        end
        step(1'b1, st, e);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw);
        logic [5:0] op;
        bit         to;
        ctrl_t      e;
        int         f;
        cur_instr = ins;
        op        = ins[31:26];
        f         = fw;
        do begin
            mem_phase(1, f, to);
            f = 0;
        end while (to);
        e = nom[2];
        if (!is_legal(op)) e.illegal = 1'b1;
        step(rnd(), 2, e);
        case (op)
            6'b000000: begin step(rnd(), 7, nom[7]); step(rnd(), 8, nom[8]); end
            6'b100011: begin
                step(rnd(), 3, nom[3]);
                mem_phase(4, mw, to);
                if (!to) step(rnd(), 5, nom[5]);
            end
            6'b101011: begin step(rnd(), 3, nom[3]); mem_phase(6, mw, to); end
            6'b000100: step(rnd(), 9, nom[9]);
            6'b000010: step(rnd(), 10, nom[10]);
            6'b001000: begin step(rnd(), 11, nom[11]); step(rnd(), 12, nom[12]); end
            default: ;
        endcase
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0]  ops[6];
        logic [5:0]  op;
        logic [31:0] r;
        bit          to;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        for (int s = 0; s < 13; s++) nom[s] = '0;
        nom[1].MemRead = 1'b1;  nom[1].ALUSrcB = 2'b01;
        nom[2].ALUSrcB = 2'b11;
        nom[3].ALUSrcA = 1'b1;  nom[3].ALUSrcB = 2'b10;
        nom[4].MemRead = 1'b1;  nom[4].IorD = 1'b1;
        nom[5].RegWrite = 1'b1; nom[5].MemToReg = 1'b1;
        nom[6].MemWrite = 1'b1; nom[6].IorD = 1'b1;
        nom[7].ALUSrcA = 1'b1;  nom[7].ALUOp = 2'b10;
        nom[8].RegWrite = 1'b1; nom[8].RegDst = 1'b1;
        nom[9].ALUSrcA = 1'b1;  nom[9].ALUOp = 2'b01;
        nom[9].PCWriteCond = 1'b1; nom[9].PCSource = 2'b01;
        nom[10].PCWrite = 1'b1; nom[10].PCSource = 2'b10;
        nom[11].ALUSrcA = 1'b1; nom[11].ALUSrcB = 2'b10;
        nom[12].RegWrite = 1'b1;

        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.instruction = '0;
        cur_instr = '0;
        rst_cycle(1'b0);
        rst_cycle(1'b0);
        rst_cycle(1'b1);

        run_instr(32'h012A4020, 0, 0);
        run_instr(32'h8D090004, 0, 3);
        run_instr(32'h11090003, 0, 0);
        run_instr(32'hFC000000, 0, 0);
        run_instr(32'hAD090008, 0, TO);
        run_instr(32'h21290001, TO, 0);
        run_instr(32'h08000010, 2, 0);

        // Reset asserted while a store is waiting on memory.
        cur_instr = 32'hAD09000C;
        mem_phase(1, 0, to);
        step(rnd(), 2, nom[2]);
        step(rnd(), 3, nom[3]);
        step(1'b0, 6, nom[6]);
        rst_cycle(1'b0);
        rst_cycle(1'b0);
        rst_cycle(1'b1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            r = $urandom;
            run_instr({op, r[25:0]}, rand_wait(), rand_wait());
        end

        @(posedge clk);
        @(negedge clk); #1;
        drv_done = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        exp_t  x;
        ctrl_t a;
        forever begin
            @(negedge clk);
            if (!drv_done && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                a.PCWrite     = bus.PCWrite;
                a.PCWriteCond = bus.PCWriteCond;
                a.IorD        = bus.IorD;
                a.MemRead     = bus.MemRead;
                a.MemWrite    = bus.MemWrite;
                a.IRWrite     = bus.IRWrite;
                a.MemToReg    = bus.MemToReg;
                a.RegDst      = bus.RegDst;
                a.RegWrite    = bus.RegWrite;
                a.ALUSrcA     = bus.ALUSrcA;
                a.ALUSrcB     = bus.ALUSrcB;
                a.ALUOp       = bus.ALUOp;
                a.PCSource    = bus.PCSource;
                a.illegal     = bus.illegal;
                a.mem_timeout = bus.mem_timeout;
                n_cmp++;
                if (bus.state !== x.st || a !== x.c) begin
                    n_bad++;
                    $display("FAIL cycle@%0t: state=%0d ctrl=%h, required state=%0d ctrl=%h",
                             $time, bus.state, a, x.st, x.c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
